// File: rtl/matrix_add_if.sv
// Handshake/bus bundle between the matrix-adder initiator and its host, adder and sink.
// The master view is the initiator itself; the slave view is everything around it.
interface matrix_add_if #(
  parameter int N = 2,
  parameter int W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [N*N*W-1:0] A;
  logic [N*N*W-1:0] B;
  logic             A_stb;
  logic             B_stb;
  logic             result_ready;
  logic             result_ack;
  logic [N*N*W-1:0] result;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  in_valid, in_data, result_ready, result, out_ready,
    output in_ready, A, B, A_stb, B_stb, result_ack,
           out_valid, out_data, out_last, busy, timeout_err
  );

  modport slave (
    output in_valid, in_data, result_ready, result, out_ready,
    input  in_ready, A, B, A_stb, B_stb, result_ack,
           out_valid, out_data, out_last, busy, timeout_err
  );
endinterface

// File: rtl/matrix_add_initiator.sv
// Initiator for the matrix adder: packs streamed A/B elements, strobes the adder,
// captures its result exactly once and streams the result matrix back out.
module matrix_add_initiator #(
  parameter int N       = 2,
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  matrix_add_if.master bus
);
  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, REQ, ACK, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NE*W-1:0] a_q, a_d;
  logic [NE*W-1:0] b_q, b_d;
  logic [NE*W-1:0] res_q, res_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            stb_q, stb_d;
  logic            ack_q, ack_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;
  logic            timeout_err_q, timeout_err_d;

  logic            loading;
  logic            accept;
  logic            idx_last;
  logic [IW-1:0]   idx_nxt;

  assign loading  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept   = loading && bus.in_valid;
  assign idx_last = (idx_q == LAST_IDX);
  assign idx_nxt  = idx_q + IW'(1);

  // NOTE: every *_d starts from its *_q so no path through this block can infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    out_data_d    = out_data_q;
    stb_d         = stb_q;
    ack_d         = ack_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      LOAD_A: begin
        if (accept) begin
          a_d[int'(idx_q)*W +: W] = bus.in_data;
          idx_d = idx_last ? '0 : idx_nxt;
          if (idx_last) state_d = LOAD_B;
        end
      end

      LOAD_B: begin
        if (accept) begin
          b_d[int'(idx_q)*W +: W] = bus.in_data;
          idx_d = idx_last ? '0 : idx_nxt;
          if (idx_last) begin
            state_d = REQ;
            stb_d   = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end

      REQ: begin
        if (bus.result_ready) begin
          res_d   = bus.result;
          ack_d   = 1'b1;
          stb_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACK;
        end else if (cnt_q == LAST_CNT) begin
          // Abandon the operation; A/B keep their contents until reloaded.
          timeout_err_d = 1'b1;
          stb_d         = 1'b0;
          busy_d        = 1'b0;
          cnt_d         = '0;
          state_d       = LOAD_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ACK: begin
        if (!bus.result_ready) begin
          ack_d       = 1'b0;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = res_q[0 +: W];
          out_last_d  = (NE == 1);
          state_d     = DRAIN;
        end
      end

      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            idx_d       = '0;
            state_d     = LOAD_A;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = res_q[int'(idx_nxt)*W +: W];
            out_last_d = (idx_nxt == LAST_IDX);
          end
        end
      end

      default: state_d = LOAD_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= LOAD_A;
      idx_q         <= '0;
      cnt_q         <= '0;
      // NOTE: the wide operand/result registers are reset too, because they drive ports that must read 0.
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      out_data_q    <= '0;
      stb_q         <= 1'b0;
      ack_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      out_data_q    <= out_data_d;
      stb_q         <= stb_d;
      ack_q         <= ack_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.in_ready    = loading && reset;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.A_stb       = stb_q;
  assign bus.B_stb       = stb_q;
  assign bus.result_ack  = ack_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_matrix_add_initiator.sv
// Bench for matrix_add_initiator: directed and random operations against an adder model,
// with a scoreboard queue of expected result beats checked by an independent monitor.
module tb_matrix_add_initiator;
  localparam int N       = 2;
  localparam int W       = 32;
  localparam int NE      = N * N;
  localparam int TIMEOUT = 64;
  localparam int MAXWAIT = 500;

  typedef logic [NE*W-1:0] vec_t;
  typedef struct {
    logic [W-1:0] data;
    bit           last;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  matrix_add_if #(.N(N), .W(W)) bus();

  matrix_add_initiator #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    or_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [W-1:0] op_a[NE];
  logic [W-1:0] op_b[NE];
  logic [W-1:0] op_r[NE];

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t pack(input logic [W-1:0] e[NE]);
    vec_t p;
    for (int k = 0; k < NE; k++) p[k*W +: W] = e[k];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expected beat for every transfer the DUT presents.
  initial begin
    logic [W-1:0] held;
    bit           stalled;
    beat_t        e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled && bus.out_valid) check("out_data_hold", vec_t'(bus.out_data), vec_t'(held));
        stalled = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected no output", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", vec_t'(bus.out_data), vec_t'(e.data));
            check1("out_last", bus.out_last, e.last);
          end
        end else if (bus.out_valid) begin
          held    = bus.out_data;
          stalled = 1'b1;
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      tick();
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic set_nominal();
    op_a = '{32'h40BAE148, 32'h41028F5C, 32'hC040A3D7, 32'hC1200000};
    op_b = '{32'h41A73333, 32'hC14CCCCD, 32'h4115999A, 32'h40000000};
    op_r = '{32'h41D5EB85, 32'hC0947AE1, 32'h40CAE148, 32'hC1000000};
  endtask

  task automatic set_random();
    for (int k = 0; k < NE; k++) begin
      op_a[k] = $urandom();
      op_b[k] = $urandom();
      op_r[k] = $urandom();
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < NE; k++) exp_q.push_back('{data: op_r[k], last: (k == NE - 1)});
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clk);
    while (!bus.in_ready && n < MAXWAIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= MAXWAIT) check1("in_ready_wait", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom();
  endtask

  // gap_mode 0: back to back, 1: idle cycle before every odd word, 2: random idles
  task automatic load_op(input int gap_mode);
    for (int k = 0; k < 2 * NE; k++) begin
      if (gap_mode == 1 && (k % 2) == 1) tick();
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
      if (k == 2 * NE - 1) check1("stb_low_during_load", bus.A_stb | bus.B_stb, 1'b0);
      send_word((k < NE) ? op_a[k] : op_b[k - NE]);
    end
  endtask

  task automatic check_req_entry();
    @(negedge clk);
    check1("a_stb_rise", bus.A_stb, 1'b1);
    check1("b_stb_rise", bus.B_stb, 1'b1);
    check1("busy_req", bus.busy, 1'b1);
    check1("in_ready_req", bus.in_ready, 1'b0);
    check("a_packed", bus.A, pack(op_a));
    check("b_packed", bus.B, pack(op_b));
  endtask

  // Adder model: waits, presents the result, holds it, then watches the ack handshake.
  task automatic respond(input int delay, input int hold);
    vec_t pa, pb;
    pa = pack(op_a);
    pb = pack(op_b);
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom();
    for (int i = 0; i < delay; i++) begin
      tick();
      @(negedge clk);
      check("a_stable", bus.A, pa);
      check("b_stable", bus.B, pb);
      check1("stb_held", bus.A_stb & bus.B_stb, 1'b1);
    end
    tick();
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b1;
    bus.result       = pack(op_r);
    tick();
    bus.result = ~pack(op_r);
    @(negedge clk);
    check1("ack_rise", bus.result_ack, 1'b1);
    check1("stb_drop", bus.A_stb | bus.B_stb, 1'b0);
    check1("busy_ack", bus.busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      tick();
      @(negedge clk);
      check1("ack_hold", bus.result_ack, 1'b1);
    end
    tick();
    bus.result_ready = 1'b0;
    bus.result       = vec_t'({$urandom(), $urandom(), $urandom(), $urandom()});
    @(negedge clk);
    check1("ack_until_low", bus.result_ack, 1'b1);
    tick();
    @(negedge clk);
    check1("ack_fall", bus.result_ack, 1'b0);
    check1("out_valid_rise", bus.out_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.out_valid) && n < MAXWAIT);
    check_int("drain_cycles_bounded", int'(n < MAXWAIT), 1);
    check_int("scoreboard_empty", exp_q.size(), 0);
    check1("in_ready_idle", bus.in_ready, 1'b1);
    tick();
  endtask

  task automatic run_op(input int gap_mode, input int delay, input int hold, input bit stall);
    load_op(gap_mode);
    check_req_entry();
    push_expected();
    respond(delay, hold);
    if (stall) begin
      tick();
      or_mode = 2;
      repeat (5) tick();
      or_mode = 0;
    end
    wait_idle();
  endtask

  task automatic apply_reset(input int cycles);
    tick();
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b0;
    reset            = 1'b0;
    tick();
    @(negedge clk);
    check("rst_a", bus.A, '0);
    check("rst_b", bus.B, '0);
    check1("rst_stb", bus.A_stb | bus.B_stb, 1'b0);
    check1("rst_ack", bus.result_ack, 1'b0);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", vec_t'(bus.out_data), '0);
    check1("rst_out_last", bus.out_last, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_timeout_err", bus.timeout_err, 1'b0);
    check1("rst_in_ready", bus.in_ready, 1'b0);
    repeat (cycles) tick();
    reset = 1'b1;
    @(negedge clk);
    check1("in_ready_after_reset", bus.in_ready, 1'b1);
    tick();
  endtask

  initial begin
    int n;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.result_ready = 1'b0;
    bus.result       = '0;
    apply_reset(2);

    set_nominal();
    run_op(0, 3, 0, 1'b0);

    set_nominal();
    run_op(1, 2, 1, 1'b1);

    set_random();
    run_op(2, 50, 3, 1'b0);

    // Adder never answers: the request must be abandoned after TIMEOUT cycles.
    set_random();
    load_op(0);
    check_req_entry();
    n = 1;
    while (n < 2 * TIMEOUT) begin
      @(negedge clk);
      if (!bus.A_stb) break;
      n++;
    end
    check_int("req_cycles_before_timeout", n, TIMEOUT);
    check1("timeout_err_set", bus.timeout_err, 1'b1);
    check1("timeout_stb_drop", bus.B_stb, 1'b0);
    check1("timeout_in_ready", bus.in_ready, 1'b1);
    check1("timeout_busy", bus.busy, 1'b0);
    check1("timeout_no_out", bus.out_valid, 1'b0);
    tick();

    set_random();
    run_op(0, 5, 0, 1'b0);
    check1("timeout_err_sticky", bus.timeout_err, 1'b1);

    // Reset part-way through loading B.
    set_random();
    for (int k = 0; k < NE + 2; k++) send_word((k < NE) ? op_a[k] : op_b[k - NE]);
    apply_reset(1);
    set_random();
    run_op(2, 7, 1, 1'b0);

    // Reset while result_ack is pending: the captured result must never appear.
    set_random();
    load_op(0);
    check_req_entry();
    tick();
    bus.result_ready = 1'b1;
    bus.result       = pack(op_r);
    tick();
    @(negedge clk);
    check1("ack_before_reset", bus.result_ack, 1'b1);
    apply_reset(1);
    set_nominal();
    run_op(0, 1, 0, 1'b0);

    or_mode = 1;
    for (int t = 0; t < 6; t++) begin
      set_random();
      run_op(2, $urandom_range(1, 40), $urandom_range(0, 3), 1'b0);
    end
    or_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_add_initiator.md
Name: matrix_add_initiator

Overview:
Initiator side of the matrix-adder operand/result handshake. It accepts A and B matrix elements as a 32-bit word stream and packs them into the flat A/B buses. It then strobes the adder and waits for result_ready, acknowledges and captures the result, and streams the result matrix back out one element per beat. Sits between the word-wide host/loader path and a tbt_adder / fbf_adder instance.

Parameters:
N, 2, matrix dimension (2 pairs with tbt_adder, 4 with fbf_adder)
W, 32, element width (IEEE-754 single)
TIMEOUT, 1024, max cycles spent in REQ waiting for result_ready before abort

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  upstream element valid
in_ready  output  1  element accepted when in_valid & in_ready
in_data  input  W  element; N*N A elements row-major, then N*N B elements
A  output  N*N*W  packed A; element k at [k*W +: W]
B  output  N*N*W  packed B, same packing
A_stb  output  1  A operand valid to adder
B_stb  output  1  B operand valid to adder
result_ready  input  1  adder result valid
result_ack  output  1  result consumed
result  input  N*N*W  packed adder result
out_valid  output  1  result element valid
out_ready  input  1  downstream accepts element
out_data  output  W  result element, row-major
out_last  output  1  high with final element (k = N*N-1)
busy  output  1  high in REQ, ACK, DRAIN
timeout_err  output  1  sticky; set on REQ timeout, cleared only by reset

Behaviour:
- Reset (reset==0 at posedge): state=LOAD_A, idx=0, wait counter=0, res_reg=0. All outputs 0: A, B, A_stb, B_stb, result_ack, out_valid, out_data, out_last, busy, timeout_err. in_ready is 0 while reset is low.
- idx: counter of width clog2(N*N), shared by LOAD_A, LOAD_B and DRAIN.
- LOAD_A: in_ready=1. On each accept, A[idx*W +: W] <= in_data and idx++. On accepting idx==N*N-1, idx<=0 and go to LOAD_B.
- LOAD_B: same as LOAD_A, writing B. After the last accept go to REQ; A_stb and B_stb are registered high on that same edge.
- REQ: A_stb=B_stb=1; A and B held stable; in_ready=0; wait counter increments each cycle.
  - On the first cycle with result_ready=1: res_reg<=result, result_ack<=1, A_stb<=B_stb<=0, counter<=0, go to ACK.
  - If the counter reaches TIMEOUT-1 without result_ready: timeout_err<=1, strobes<=0, go to LOAD_A. A and B keep their old values until overwritten.
- ACK: result_ack held at 1 until result_ready is sampled 0. On that edge result_ack<=0, idx<=0, go to DRAIN. Minimum ACK residency is 1 cycle.
- DRAIN: out_valid=1, out_data=res_reg[idx*W +: W], out_last=(idx==N*N-1), all registered.
  - out_data is held while out_ready=0.
  - On out_valid & out_ready: idx++.
  - After the last element transfers: out_valid<=0, out_last<=0, idx<=0, go to LOAD_A.
- Latency:
  - LOAD_A to REQ takes a minimum of 2*N*N accept cycles.
  - result_ready seen to result_ack high: 1 cycle.
  - result_ready low to first out_valid: 1 cycle.
- Simultaneous events:
  - result_ready at the same edge the strobes rise is ignored; it is first sampled in REQ.
  - in_valid outside LOAD_A/LOAD_B is ignored and never accepted.
  - Result is captured exactly once per operation.
- Reset mid-operation (any state): immediate return to reset values. A partially loaded matrix is discarded; a pending result_ack is dropped in the same cycle.
- No arithmetic is done here; elements pass bit-exact.

Test Plan:
- N=2 nominal: stream A=40BAE148,41028F5C,C040A3D7,C1200000 then B=41A73333,C14CCCCD,4115999A,40000000 into a tbt_adder (or model).
  - A_stb and B_stb rise 1 cycle after the 8th accept.
  - result_ack pulses; out_data sequence is 41D5EB85, C0947AE1, 40CAE148, C1000000.
  - out_last on the 4th element only.
- Backpressure: toggle in_valid 1-0-1 during load and hold out_ready=0 for 5 cycles mid-drain. No element is lost or duplicated; out_data stays stable while stalled; same 4 result words.
- Slow adder model (result_ready after 50 cycles, held 3 cycles after ack): A/B stable throughout REQ; result_ack high until result_ready falls; exactly one capture.
- Timeout with TIMEOUT=16 and result_ready tied 0: timeout_err=1 on the 16th REQ cycle; strobes drop; in_ready=1 next cycle; no out_valid.
- Reset low in the middle of LOAD_B (after 2 B words) and again in ACK: all outputs return to 0 on the next edge. A subsequent full transaction produces the correct results.
- N=4 with fbf_adder: first A element 3F99999A, first B element 415A147B. out_data[0]=416D47AE, out_data[15]=4146B852; 16 beats total; out_last on beat 16.
